clock_domain_reset_sequencer: RTL and testbench



---
 rtl/clock_domain_reset_sequencer.sv | 138 +++++++++++++
 tb/tb_clock_domain_reset_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_domain_reset_sequencer.sv
// Reset and clock-enable sequencer for up to 16 downstream clock domains.
// A power-on sequence follows its own reset; runtime requests re-reset a masked subset of domains.
module clock_domain_reset_sequencer #(
  parameter int N_DOMAINS   = 4,
  parameter int QUIESCE_CYC = 8,
  parameter int HOLD_CYC    = 16,
  parameter int STAGGER_CYC = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [N_DOMAINS-1:0] req_mask,
  output logic [N_DOMAINS-1:0] domain_reset,
  output logic [N_DOMAINS-1:0] domain_clock_en,
  output logic                 busy,
  output logic                 done
);

  localparam int MAX_QH  = (QUIESCE_CYC > HOLD_CYC) ? QUIESCE_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_QH > STAGGER_CYC) ? MAX_QH : STAGGER_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int IW      = $clog2(N_DOMAINS + 1);
  localparam logic [IW-1:0] NO_IDX = IW'(N_DOMAINS);

  typedef enum logic [2:0] {ASSERT, QUIESCE, RELEASE, DONE, IDLE} state_t;

  state_t               state, nxt_state;
  logic [CW-1:0]        cnt, nxt_cnt;
  logic [IW-1:0]        idx, nxt_idx, drop_idx;
  logic [N_DOMAINS-1:0] mask, nxt_mask, nxt_rst, nxt_en;
  logic                 do_drop;

  // Lowest masked index at or above 'from', or NO_IDX when none remain.
  function automatic logic [IW-1:0] next_masked(input logic [N_DOMAINS-1:0] m, input int from);
    logic [IW-1:0] r;
    r = NO_IDX;
    for (int i = N_DOMAINS - 1; i >= 0; i--)
      if (i >= from && m[i]) r = IW'(i);
    return r;
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    nxt_mask  = mask;
    nxt_rst   = domain_reset;
    nxt_en    = domain_clock_en;
    drop_idx  = NO_IDX;
    do_drop   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          nxt_mask = req_mask;
          if (req_mask == '0) begin
            nxt_state = DONE;
          end else begin
            nxt_state = QUIESCE;
            nxt_cnt   = CW'(QUIESCE_CYC - 1);
            nxt_en    = domain_clock_en & ~req_mask;
          end
        end
      end
      QUIESCE: begin
        if (cnt == '0) begin
          nxt_state = ASSERT;
          nxt_cnt   = CW'(HOLD_CYC - 1);
          nxt_rst   = domain_reset | mask;
          nxt_en    = domain_clock_en | mask;
        end else begin
          nxt_cnt = cnt - CW'(1);
        end
      end
      ASSERT: begin
        nxt_rst = domain_reset | mask;
        nxt_en  = domain_clock_en | mask;
        if (cnt == '0) begin
          drop_idx = next_masked(mask, 0);
          do_drop  = 1'b1;
        end else begin
          nxt_cnt = cnt - CW'(1);
        end
      end
      RELEASE: begin
        if (idx == NO_IDX) begin
          nxt_state = DONE;
        end else if (cnt == '0) begin
          drop_idx = idx;
          do_drop  = 1'b1;
        end else begin
          nxt_cnt = cnt - CW'(1);
        end
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase

    // A drop releases one domain now and arms the stagger timer for the next masked one;
    // after the last drop idx parks at NO_IDX so RELEASE exits on the following edge.
    if (do_drop) begin
      if (drop_idx == NO_IDX) begin
        nxt_state = DONE;
      end else begin
        for (int i = 0; i < N_DOMAINS; i++)
          if (IW'(i) == drop_idx) nxt_rst[i] = 1'b0;
        nxt_idx   = next_masked(mask, int'(drop_idx) + 1);
        nxt_cnt   = CW'(STAGGER_CYC - 1);
        nxt_state = RELEASE;
      end
    end
  end

  // Reset parks in ASSERT with one extra count so the first post-reset cycle starts the hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ASSERT;
      cnt             <= CW'(HOLD_CYC);
      idx             <= NO_IDX;
      mask            <= '1;
      domain_reset    <= '1;
      domain_clock_en <= '0;
      done            <= 1'b0;
    end else begin
      state           <= nxt_state;
      cnt             <= nxt_cnt;
      idx             <= nxt_idx;
      mask            <= nxt_mask;
      domain_reset    <= nxt_rst;
      domain_clock_en <= nxt_en;
      done            <= (nxt_state == DONE);
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_clock_domain_reset_sequencer.sv
// Bench for clock_domain_reset_sequencer: default instance plus a minimal-timing two-domain instance,
// checked every cycle against a schedule model built from per-domain event times.
module tb_clock_domain_reset_sequencer;

  localparam int NA = 4, QA = 8, HA = 16, SA = 4;
  localparam int NB = 2, QB = 1, HB = 1, SB = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int tick = 0;
  always @(posedge clock) tick <= tick + 1;

  logic          reset_a, req_valid_a, req_ready_a, busy_a, done_a;
  logic [NA-1:0] req_mask_a, domain_reset_a, domain_clock_en_a;
  logic          reset_b, req_valid_b, req_ready_b, busy_b, done_b;
  logic [NB-1:0] req_mask_b, domain_reset_b, domain_clock_en_b;

  clock_domain_reset_sequencer #(
    .N_DOMAINS(NA), .QUIESCE_CYC(QA), .HOLD_CYC(HA), .STAGGER_CYC(SA)
  ) dut_a (
    .clock(clock), .reset(reset_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_mask(req_mask_a), .domain_reset(domain_reset_a), .domain_clock_en(domain_clock_en_a),
    .busy(busy_a), .done(done_a)
  );

  clock_domain_reset_sequencer #(
    .N_DOMAINS(NB), .QUIESCE_CYC(QB), .HOLD_CYC(HB), .STAGGER_CYC(SB)
  ) dut_b (
    .clock(clock), .reset(reset_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_mask(req_mask_b), .domain_reset(domain_reset_b), .domain_clock_en(domain_clock_en_b),
    .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] brst_a, ben_a, brst_b, ben_b;

  // Expected outputs at absolute cycle k for a sequence whose first cycle is 'base' (q=0 for power-on).
  // The masked domain of rank r drops reset at base+q+h+r*s; done follows the last drop by one cycle.
  function automatic void model(input int k, input int base, input int q, input int h, input int s,
                                input int n, input logic [15:0] mask, input logic [15:0] brst,
                                input logic [15:0] ben, output logic [15:0] rst,
                                output logic [15:0] en, output logic dn, output logic rdy);
    int pc, r, done_c;
    pc = 0;
    for (int i = 0; i < n; i++) if (mask[i]) pc++;
    done_c = (pc == 0) ? base : base + q + h + (pc - 1) * s + 1;
    rst = brst;
    en  = ben;
    r   = 0;
    for (int i = 0; i < n; i++) begin
      if (mask[i]) begin
        if (k < base + q) begin
          en[i] = 1'b0;
        end else begin
          en[i]  = 1'b1;
          rst[i] = (k < base + q + h + r * s);
        end
        r++;
      end
    end
    dn  = (k == done_c);
    rdy = (k > done_c);
  endfunction

  task automatic test_reset();
    reset_a = 1'b1; req_valid_a = 1'b0; req_mask_a = '0;
    reset_b = 1'b1; req_valid_b = 1'b0; req_mask_b = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({domain_reset_a, domain_clock_en_a, done_a, req_ready_a, busy_a} !== {4'hF, 4'h0, 3'b001}) begin
      errors++;
      $display("[TB] FAIL reset_a: got %b want %b", {domain_reset_a, domain_clock_en_a, done_a, req_ready_a, busy_a}, {4'hF, 4'h0, 3'b001});
    end
    checks++;
    if ({domain_reset_b, domain_clock_en_b, done_b, req_ready_b, busy_b} !== {2'b11, 2'b00, 3'b001}) begin
      errors++;
      $display("[TB] FAIL reset_b: got %b want %b", {domain_reset_b, domain_clock_en_b, done_b, req_ready_b, busy_b}, {2'b11, 2'b00, 3'b001});
    end
  endtask

  task automatic test_power_on();
    int base, k;
    logic [15:0] er, ee;
    logic dn, rdy;
    logic [10:0] exp_v, act_v;
    reset_a = 1'b0;
    base = tick + 1;
    do begin
      @(negedge clock);
      k = tick;
      model(k, base, 0, HA, SA, NA, 16'h000F, 16'h000F, 16'h0000, er, ee, dn, rdy);
      exp_v = {er[3:0], ee[3:0], dn, rdy, ~rdy};
      act_v = {domain_reset_a, domain_clock_en_a, done_a, req_ready_a, busy_a};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL power_on cycle %0d: got %b want %b (rst,en,done,ready,busy)", k - base, act_v, exp_v);
      end
    end while (!rdy);
    brst_a = 16'h0000;
    ben_a  = 16'h000F;
  endtask

  task automatic test_runtime_requests();
    logic [3:0] masks [8];
    int base, k, gap;
    logic [15:0] er, ee;
    logic dn, rdy;
    logic [10:0] exp_v, act_v;
    masks[0] = 4'b0101;
    masks[1] = 4'b0000;
    for (int i = 2; i < 8; i++) masks[i] = 4'($urandom_range(0, 15));
    for (int it = 0; it < 8; it++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        checks++;
        if ({domain_reset_a, domain_clock_en_a, done_a, req_ready_a, busy_a} !== {brst_a[3:0], ben_a[3:0], 3'b010}) begin
          errors++;
          $display("[TB] FAIL idle_gap: got %b want %b", {domain_reset_a, domain_clock_en_a, done_a, req_ready_a, busy_a}, {brst_a[3:0], ben_a[3:0], 3'b010});
        end
      end
      req_valid_a = 1'b1;
      req_mask_a  = masks[it];
      base = tick + 1;
      do begin
        @(negedge clock);
        k = tick;
        model(k, base, QA, HA, SA, NA, {12'h0, masks[it]}, brst_a, ben_a, er, ee, dn, rdy);
        exp_v = {er[3:0], ee[3:0], dn, rdy, ~rdy};
        act_v = {domain_reset_a, domain_clock_en_a, done_a, req_ready_a, busy_a};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("[TB] FAIL request mask %b cycle %0d: got %b want %b", masks[it], k - base, act_v, exp_v);
        end
        if (k == base) req_valid_a = 1'b0;
      end while (!rdy);
      brst_a = brst_a & ~{12'h0, masks[it]};
      ben_a  = ben_a | {12'h0, masks[it]};
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] masks [3];
    int base, k;
    logic [15:0] er, ee;
    logic dn, rdy;
    logic [10:0] exp_v, act_v;
    for (int i = 0; i < 3; i++) masks[i] = 4'($urandom_range(1, 15));
    req_valid_a = 1'b1;
    req_mask_a  = masks[0];
    for (int sq = 0; sq < 3; sq++) begin
      base = tick + 1;
      do begin
        @(negedge clock);
        k = tick;
        model(k, base, QA, HA, SA, NA, {12'h0, masks[sq]}, brst_a, ben_a, er, ee, dn, rdy);
        exp_v = {er[3:0], ee[3:0], dn, rdy, ~rdy};
        act_v = {domain_reset_a, domain_clock_en_a, done_a, req_ready_a, busy_a};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("[TB] FAIL back_to_back seq %0d cycle %0d: got %b want %b", sq, k - base, act_v, exp_v);
        end
        if (k == base) begin
          if (sq < 2) req_mask_a = masks[sq + 1];
          else req_valid_a = 1'b0;
        end
      end while (!rdy);
      brst_a = brst_a & ~{12'h0, masks[sq]};
      ben_a  = ben_a | {12'h0, masks[sq]};
    end
  endtask

  task automatic test_reset_mid_release();
    int base, k;
    logic [3:0] m;
    logic [15:0] er, ee;
    logic dn, rdy;
    logic [10:0] exp_v, act_v;
    reset_a = 1'b1;
    @(negedge clock);
    reset_a = 1'b0;
    m = 4'($urandom_range(1, 15));
    req_valid_a = 1'b1;
    req_mask_a  = m;
    base = tick + 1;
    do begin
      @(negedge clock);
      k = tick;
      model(k, base, 0, HA, SA, NA, 16'h000F, 16'h000F, 16'h0000, er, ee, dn, rdy);
      exp_v = {er[3:0], ee[3:0], dn, rdy, ~rdy};
      act_v = {domain_reset_a, domain_clock_en_a, done_a, req_ready_a, busy_a};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL pre_reset cycle %0d: got %b want %b", k - base, act_v, exp_v);
      end
    end while (k - base < 22);
    reset_a = 1'b1;
    @(negedge clock);
    checks++;
    if ({domain_reset_a, domain_clock_en_a, done_a, req_ready_a, busy_a} !== {4'hF, 4'h0, 3'b001}) begin
      errors++;
      $display("[TB] FAIL reset_mid_release: got %b want %b", {domain_reset_a, domain_clock_en_a, done_a, req_ready_a, busy_a}, {4'hF, 4'h0, 3'b001});
    end
    reset_a = 1'b0;
    base = tick + 1;
    do begin
      @(negedge clock);
      k = tick;
      model(k, base, 0, HA, SA, NA, 16'h000F, 16'h000F, 16'h0000, er, ee, dn, rdy);
      exp_v = {er[3:0], ee[3:0], dn, rdy, ~rdy};
      act_v = {domain_reset_a, domain_clock_en_a, done_a, req_ready_a, busy_a};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL restart_power_on cycle %0d: got %b want %b", k - base, act_v, exp_v);
      end
    end while (!rdy);
    brst_a = 16'h0000;
    ben_a  = 16'h000F;
    base = tick + 1;
    do begin
      @(negedge clock);
      k = tick;
      model(k, base, QA, HA, SA, NA, {12'h0, m}, brst_a, ben_a, er, ee, dn, rdy);
      exp_v = {er[3:0], ee[3:0], dn, rdy, ~rdy};
      act_v = {domain_reset_a, domain_clock_en_a, done_a, req_ready_a, busy_a};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL held_request cycle %0d: got %b want %b", k - base, act_v, exp_v);
      end
      if (k == base) req_valid_a = 1'b0;
    end while (!rdy);
    brst_a = brst_a & ~{12'h0, m};
    ben_a  = ben_a | {12'h0, m};
  endtask

  task automatic test_param();
    logic [1:0] masks [5];
    int base, k;
    logic [15:0] er, ee;
    logic dn, rdy;
    logic [6:0] exp_v, act_v;
    reset_b = 1'b0;
    base = tick + 1;
    do begin
      @(negedge clock);
      k = tick;
      model(k, base, 0, HB, SB, NB, 16'h0003, 16'h0003, 16'h0000, er, ee, dn, rdy);
      exp_v = {er[1:0], ee[1:0], dn, rdy, ~rdy};
      act_v = {domain_reset_b, domain_clock_en_b, done_b, req_ready_b, busy_b};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL param_power_on cycle %0d: got %b want %b", k - base, act_v, exp_v);
      end
    end while (!rdy);
    brst_b = 16'h0000;
    ben_b  = 16'h0003;
    masks[0] = 2'b11;
    for (int i = 1; i < 5; i++) masks[i] = 2'($urandom_range(0, 3));
    req_valid_b = 1'b1;
    req_mask_b  = masks[0];
    for (int sq = 0; sq < 5; sq++) begin
      base = tick + 1;
      do begin
        @(negedge clock);
        k = tick;
        model(k, base, QB, HB, SB, NB, {14'h0, masks[sq]}, brst_b, ben_b, er, ee, dn, rdy);
        exp_v = {er[1:0], ee[1:0], dn, rdy, ~rdy};
        act_v = {domain_reset_b, domain_clock_en_b, done_b, req_ready_b, busy_b};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("[TB] FAIL param_back_to_back seq %0d cycle %0d: got %b want %b", sq, k - base, act_v, exp_v);
        end
        if (k == base) begin
          if (sq < 4) req_mask_b = masks[sq + 1];
          else req_valid_b = 1'b0;
        end
      end while (!rdy);
      brst_b = brst_b & ~{14'h0, masks[sq]};
      ben_b  = ben_b | {14'h0, masks[sq]};
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_runtime_requests();
    test_back_to_back();
    test_reset_mid_release();
    test_param();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion want completion within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
